bk_adder_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's 32-bit combinational Brent-Kung adder.
- Generic power-of-two width, selectable pipeline depth, add/subtract mode, signed overflow flag and valid/ready flow control.
- Sits in datapaths that need high clock rates and backpressure, e.g. accumulator and ALU pipelines.

---
 rtl/bk_adder_pipe_if.sv | 41 ++++
 rtl/bk_adder_pipe.sv | 208 ++++++++++++++++++++
 tb/tb_bk_adder_pipe.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/bk_adder_pipe_if.sv
// Operand/result handshake bundle for bk_adder_pipe.
// BK_ADDER_PIPE_SAT_EN adds the per-beat 'sat' request bit.
interface bk_adder_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef BK_ADDER_PIPE_SAT_EN
  logic             sat;

  modport master (
    output in_valid, a, b, cin, sub, sat, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, sat, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`endif
endinterface

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready flow control.
// STAGES=1: one output register; 2: plus register after the up-sweep;
// 3: plus register after the down-sweep.
// Optional macro BK_ADDER_PIPE_SAT_EN: signed saturation selected per beat.
module bk_adder_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input logic            clk,
  input logic            rst,
  bk_adder_pipe_if.slave bus
);

  localparam int unsigned LOG_W = $clog2(WIDTH);

  generate
    if (WIDTH < 4 || WIDTH > 128 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("bk_adder_pipe: WIDTH must be a power of two in 4..128");
    end
    if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
      $error("bk_adder_pipe: STAGES must be 1, 2 or 3");
    end
  endgenerate

  // Beat after the up-sweep: g/gp hold partial group generate/propagate.
  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] gp;
    logic             c0;
    logic             neg;
    logic             sat;
  } up_t;

  // Beat after the down-sweep: c[i] is the carry out of bit i.
  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;
    logic             c0;
    logic             neg;
    logic             sat;
  } dn_t;

  // Up-sweep: after level l, index i with (i+1) % 2^(l+1) == 0 spans 2^(l+1) bits.
  function automatic logic [2*WIDTH-1:0] up_sweep(input logic [WIDTH-1:0] g_in,
                                                  input logic [WIDTH-1:0] p_in);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    int unsigned      step;
    g = g_in;
    p = p_in;
    for (int unsigned lvl = 0; lvl < LOG_W; lvl++) begin
      step = 32'd1 << lvl;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (((i + 1) % (2 * step)) == 0) begin
          g[LOG_W'(i)] = g[LOG_W'(i)] | (p[LOG_W'(i)] & g[LOG_W'(i - step)]);
          p[LOG_W'(i)] = p[LOG_W'(i)] & p[LOG_W'(i - step)];
        end
      end
    end
    return {g, p};
  endfunction

  // Down-sweep: fill in the prefixes the up-sweep left partial.
  function automatic logic [WIDTH-1:0] down_sweep(input logic [WIDTH-1:0] g_in,
                                                  input logic [WIDTH-1:0] p_in);
    logic [WIDTH-1:0] g;
    int unsigned      step;
    g = g_in;
    for (int lvl = int'(LOG_W) - 2; lvl >= 0; lvl--) begin
      step = 32'd1 << lvl;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (((i + 1) % (2 * step)) == step && i > step) begin
          g[LOG_W'(i)] = g[LOG_W'(i)] | (p_in[LOG_W'(i)] & g[LOG_W'(i - step)]);
        end
      end
    end
    return g;
  endfunction

  logic             en;
  logic             acc;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] gen;
  up_t              up_c;
  up_t              s1;
  logic             s1_v;
  dn_t              dn_c;
  dn_t              s2;
  logic             s2_v;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;
  logic             res_valid;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_ovf;

  // Whole pipe advances together; a held output stalls every stage.
  assign en           = !res_valid || bus.out_ready;
  assign acc          = bus.in_valid && en;
  assign bus.in_ready = en;

  // Operand conditioning and up-sweep; carry-in folded into bit 0's generate.
  always_comb begin
    up_c     = '0;
    bx       = bus.sub ? ~bus.b : bus.b;
    up_c.c0  = bus.sub | bus.cin;
    up_c.p   = bus.a ^ bx;
    gen      = bus.a & bx;
    gen[0]   = gen[0] | (up_c.p[0] & up_c.c0);
    {up_c.g, up_c.gp} = up_sweep(gen, up_c.p);
    // On overflow both effective operands share a's sign.
    up_c.neg = bus.a[WIDTH-1];
`ifdef BK_ADDER_PIPE_SAT_EN
    up_c.sat = bus.sat;
`else
    up_c.sat = 1'b0;
`endif
  end

  generate
    if (STAGES >= 2) begin : g_s1
      up_t  s1_q;
      logic s1_vq;
      // Register between up-sweep and down-sweep.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_q  <= '0;
          s1_vq <= 1'b0;
        end else if (en) begin
          s1_q  <= up_c;
          s1_vq <= acc;
        end
      end
      assign s1   = s1_q;
      assign s1_v = s1_vq;
    end else begin : g_s1_bypass
      assign s1   = up_c;
      assign s1_v = acc;
    end
  endgenerate

  // Down-sweep completes every carry.
  always_comb begin
    dn_c     = '0;
    dn_c.p   = s1.p;
    dn_c.c0  = s1.c0;
    dn_c.neg = s1.neg;
    dn_c.sat = s1.sat;
    dn_c.c   = down_sweep(s1.g, s1.gp);
  end

  generate
    if (STAGES >= 3) begin : g_s2
      dn_t  s2_q;
      logic s2_vq;
      // Register between down-sweep and sum XOR.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_q  <= '0;
          s2_vq <= 1'b0;
        end else if (en) begin
          s2_q  <= dn_c;
          s2_vq <= s1_v;
        end
      end
      assign s2   = s2_q;
      assign s2_v = s2_vq;
    end else begin : g_s2_bypass
      assign s2   = dn_c;
      assign s2_v = s1_v;
    end
  endgenerate

  // Sum, carry-out, signed overflow and optional saturation.
  always_comb begin
    sum_c  = s2.p ^ {s2.c[WIDTH-2:0], s2.c0};
    cout_c = s2.c[WIDTH-1];
    ovf_c  = s2.c[WIDTH-1] ^ s2.c[WIDTH-2];
    if (s2.sat && ovf_c) begin
      sum_c = s2.neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // Output register; result fields only change when a valid beat lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_ovf   <= 1'b0;
    end else if (en) begin
      res_valid <= s2_v;
      if (s2_v) begin
        res_sum  <= sum_c;
        res_cout <= cout_c;
        res_ovf  <= ovf_c;
      end
    end
  end

  assign bus.out_valid = res_valid;
  assign bus.sum       = res_sum;
  assign bus.cout      = res_cout;
  assign bus.ovf       = res_ovf;

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Directed bench for bk_adder_pipe: three instances (32b/2 stages,
// 32b/3 stages, 8b/1 stage) on a shared clock and reset.
module tb_bk_adder_pipe;

  logic clk;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  bk_adder_pipe_if #(.WIDTH(32)) b32 ();
  bk_adder_pipe_if #(.WIDTH(32)) b3 ();
  bk_adder_pipe_if #(.WIDTH(8))  b8 ();

  bk_adder_pipe #(.WIDTH(32), .STAGES(2)) u_s2 (.clk(clk), .rst(rst), .bus(b32));
  bk_adder_pipe #(.WIDTH(32), .STAGES(3)) u_s3 (.clk(clk), .rst(rst), .bus(b3));
  bk_adder_pipe #(.WIDTH(8),  .STAGES(1)) u_w8 (.clk(clk), .rst(rst), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {sum, cout, ovf} from plain wide addition and the sign rule.
  function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
    logic [31:0] bb;
    logic [32:0] r;
    logic        v;
    bb = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + 33'(sub ? 1'b1 : cin);
    v  = (a[31] == bb[31]) && (r[31] != a[31]);
    return {r[31:0], r[32], v};
  endfunction

  task automatic beat_s2(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub);
    b32.in_valid = v; b32.a = a; b32.b = b; b32.cin = cin; b32.sub = sub;
  endtask

  task automatic beat_s3(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub);
    b3.in_valid = v; b3.a = a; b3.b = b; b3.cin = cin; b3.sub = sub;
  endtask

  task automatic beat_w8(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub);
    b8.in_valid = v; b8.a = a; b8.b = b; b8.cin = cin; b8.sub = sub;
  endtask

  logic [33:0] exp_q[$];
  logic [33:0] stall_exp [3];
  logic [33:0] e;
  logic [31:0] ra;
  logic [31:0] rb;
  logic        rc;
  logic        rs;
  logic [31:0] ovf_sum;
  int          first_out;
  int          last_out;
  int          got;
  int          sent;

  initial begin
    rst = 1'b1;
    beat_s2(1'b0, '0, '0, 1'b0, 1'b0);
    beat_s3(1'b0, '0, '0, 1'b0, 1'b0);
    beat_w8(1'b0, '0, '0, 1'b0, 1'b0);
    b32.out_ready = 1'b1;
    b3.out_ready  = 1'b1;
    b8.out_ready  = 1'b1;
`ifdef BK_ADDER_PIPE_SAT_EN
    b32.sat = 1'b0;
    b3.sat  = 1'b0;
    b8.sat  = 1'b0;
    ovf_sum = 32'h7FFF_FFFF;
`else
    ovf_sum = 32'h8000_0000;
`endif
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'({b32.out_valid, b3.out_valid, b8.out_valid}), 64'(0));
    chk("rst_s2_data", 64'({b32.sum, b32.cout, b32.ovf}), 64'(0));
    chk("rst_w8_data", 64'({b8.sum, b8.cout, b8.ovf}), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 64'({b32.in_ready, b3.in_ready, b8.in_ready}), 64'(3'b111));

    // STAGES=2 directed vectors, back to back.
    beat_s2(1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    @(negedge clk);
    chk("s2_not_early", 64'(b32.out_valid), 64'(0));
    beat_s2(1'b1, 32'hFFFF_0006, 32'h1256_0006, 1'b0, 1'b0);
    @(negedge clk);
    chk("s2_1plus1", 64'({b32.out_valid, b32.sum, b32.cout, b32.ovf}),
        64'({1'b1, 32'h0000_0002, 1'b0, 1'b0}));
    beat_s2(1'b1, 32'h0000_0010, 32'h6666_0010, 1'b0, 1'b1);
    @(negedge clk);
    chk("s2_add_cout", 64'({b32.out_valid, b32.sum, b32.cout, b32.ovf}),
        64'({1'b1, 32'h1255_000C, 1'b1, 1'b0}));
    beat_s2(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
`ifdef BK_ADDER_PIPE_SAT_EN
    b32.sat = 1'b1;
`endif
    @(negedge clk);
    chk("s2_sub_borrow", 64'({b32.out_valid, b32.sum, b32.cout, b32.ovf}),
        64'({1'b1, 32'h999A_0000, 1'b0, 1'b0}));
    b32.in_valid = 1'b0;
`ifdef BK_ADDER_PIPE_SAT_EN
    b32.sat = 1'b0;
`endif
    @(negedge clk);
    chk("s2_ovf", 64'({b32.out_valid, b32.sum, b32.cout, b32.ovf}),
        64'({1'b1, ovf_sum, 1'b0, 1'b1}));
    @(negedge clk);
    chk("s2_drained", 64'(b32.out_valid), 64'(0));
    chk("s2_idle_hold", 64'({b32.sum, b32.cout, b32.ovf}), 64'({ovf_sum, 1'b0, 1'b1}));

    // STAGES=3 stream of 48 random beats with out_ready high.
    first_out = -1;
    last_out  = -1;
    got       = 0;
    sent      = 0;
    for (int c = 0; c < 70; c++) begin
      if (b3.out_valid) begin
        if (first_out < 0) first_out = c;
        last_out = c;
        if (exp_q.size() == 0) begin
          chk("s3_extra_result", 64'(b3.out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("s3_stream", 64'({b3.sum, b3.cout, b3.ovf}), 64'(e));
          got++;
        end
      end
      if (sent < 48) begin
        ra = $urandom();
        rb = $urandom();
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        beat_s3(1'b1, ra, rb, rc, rs);
        if (b3.in_ready) begin
          exp_q.push_back(ref_add(ra, rb, rc, rs));
          sent++;
        end
      end else begin
        b3.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("s3_first_latency", 64'(first_out), 64'(3));
    chk("s3_last_cycle", 64'(last_out), 64'(50));
    chk("s3_count", 64'(got), 64'(48));

    // STAGES=3 backpressure: fill, stall five cycles, release.
    b3.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ra = $urandom();
      rb = $urandom();
      rs = 1'(k == 1);
      beat_s3(1'b1, ra, rb, 1'b1, rs);
      stall_exp[k] = ref_add(ra, rb, 1'b1, rs);
      @(negedge clk);
    end
    b3.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("s3_stall_in_ready", 64'(b3.in_ready), 64'(0));
      chk("s3_stall_hold", 64'({b3.out_valid, b3.sum, b3.cout, b3.ovf}),
          64'({1'b1, stall_exp[0]}));
      @(negedge clk);
    end
    b3.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("s3_release", 64'({b3.out_valid, b3.sum, b3.cout, b3.ovf}),
          64'({1'b1, stall_exp[k]}));
      @(negedge clk);
    end
    chk("s3_release_empty", 64'({b3.out_valid, b3.in_ready}), 64'(2'b01));

    // WIDTH=8, STAGES=1 and a reset with beats in flight.
    beat_w8(1'b1, 8'hFF, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    chk("w8_wrap_cin", 64'({b8.out_valid, b8.sum, b8.cout, b8.ovf}),
        64'({1'b1, 8'h00, 1'b1, 1'b0}));
    beat_w8(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    chk("w8_ovf", 64'({b8.out_valid, b8.sum, b8.cout, b8.ovf}),
        64'({1'b1, 8'h80, 1'b0, 1'b1}));
    beat_w8(1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
    beat_s3(1'b1, 32'h0000_1234, 32'h0000_0001, 1'b0, 1'b0);
    @(negedge clk);
    chk("w8_pre_rst", 64'({b8.out_valid, b8.sum, b8.cout, b8.ovf}),
        64'({1'b1, 8'h30, 1'b0, 1'b0}));
    rst = 1'b1;
    b8.in_valid = 1'b0;
    b3.in_valid = 1'b0;
    #1;
    chk("rst_async", 64'({b8.out_valid, b8.sum, b3.out_valid}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("rst_no_stale", 64'({b8.out_valid, b3.out_valid, b32.out_valid}), 64'(0));
      @(negedge clk);
    end
    beat_w8(1'b1, 8'h01, 8'h02, 1'b1, 1'b1);
    @(negedge clk);
    chk("w8_sub_after_rst", 64'({b8.out_valid, b8.sum, b8.cout, b8.ovf}),
        64'({1'b1, 8'hFF, 1'b0, 1'b0}));
    b8.in_valid = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
